// File: rtl/click_pipe_pkg.sv
// Shared types and helpers for the click-pipeline front/back-end.
package click_pipe_pkg;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} tx_state_e;

endpackage

// File: rtl/click_id_fifo.sv
// Source-ID FIFO: one entry per token in flight, popped in return order.
module click_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Empty FIFO reads as ID 0 so a protocol error yields a defined rsp_src.
  assign o_head  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sync_ff.sv
// Flop chain bringing an asynchronous phase signal into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/click_pipe_arbiter.sv
// Round-robin front-end into a 2-phase click pipeline plus tagged response back-end.
module click_pipe_arbiter
  import click_pipe_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int SYNC_STAGES  = 2,
  localparam int ID_W  = id_w(N_REQ),
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        pipe_in_req,
  output logic [DATA_WIDTH-1:0]       pipe_in_data,
  input  logic                        pipe_in_ack,
  input  logic                        pipe_out_req,
  input  logic [DATA_WIDTH-1:0]       pipe_out_data,
  output logic                        pipe_out_ack,
  output logic                        rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]             rsp_src,
  input  logic                        rsp_ready,
  output logic [CNT_W-1:0]            inflight
);

  tx_state_e             r_state, w_state_nxt;
  logic [ID_W-1:0]       r_ptr, w_grant, w_cand, r_rsp_src, w_fifo_head;
  logic [DATA_WIDTH-1:0] r_in_data, r_rsp_data, w_sel_data;
  logic [CNT_W-1:0]      r_inflight;
  logic r_in_req, r_out_ack, r_rsp_valid;
  logic w_ack_s, w_oreq_s, w_any, w_accept, w_rx_detect, w_rsp_fire;
  logic w_fifo_full, w_fifo_empty;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .reset(reset), .i_d(pipe_in_ack), .o_q(w_ack_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_oreq (
    .clk(clk), .reset(reset), .i_d(pipe_out_req), .o_q(w_oreq_s));

  click_id_fifo #(.DEPTH(MAX_INFLIGHT), .WIDTH(ID_W)) u_id_fifo (
    .clk(clk), .reset(reset),
    .i_push(w_accept), .i_push_data(w_grant), .i_pop(w_rx_detect),
    .o_head(w_fifo_head), .o_full(w_fifo_full), .o_empty(w_fifo_empty));

  // Search starts one past the last grant, wrapping at N_REQ.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_cand  = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (w_cand == ID_W'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
      if (!w_any && req_valid[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_grant == ID_W'(i)) w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = '0;
    case (r_state)
      IDLE: if (!reset && w_any && (r_inflight < CNT_W'(MAX_INFLIGHT)) && !w_fifo_full) begin
        w_accept           = 1'b1;
        req_ready[w_grant] = 1'b1;
        w_state_nxt        = SETUP;
      end
      SETUP:    w_state_nxt = WAIT_ACK;
      WAIT_ACK: if (w_ack_s == r_in_req) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Phase mismatch means a fresh token; rsp_valid masks the stale phase until the ack toggles.
  assign w_rx_detect = (w_oreq_s != r_out_ack) && !r_rsp_valid;
  assign w_rsp_fire  = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_in_req    <= 1'b0;
      r_in_data   <= '0;
      r_out_ack   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_src   <= '0;
      r_inflight  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr     <= w_grant;
        r_in_data <= w_sel_data;
      end
      if (r_state == SETUP) r_in_req <= ~r_in_req;
      if (w_rx_detect) begin
        r_rsp_data  <= pipe_out_data;
        r_rsp_src   <= w_fifo_head;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_out_ack   <= ~r_out_ack;
      end
      if (w_accept && !w_rsp_fire)      r_inflight <= r_inflight + 1'b1;
      else if (!w_accept && w_rsp_fire) r_inflight <= r_inflight - 1'b1;
    end
  end

  a_rx_id_available: assert property (@(posedge clk) disable iff (reset)
    w_rx_detect |-> !w_fifo_empty);

  assign pipe_in_req  = r_in_req;
  assign pipe_in_data = r_in_data;
  assign pipe_out_ack = r_out_ack;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_src      = r_rsp_src;
  assign inflight     = r_inflight;

endmodule

// File: tb/tb_click_pipe_arbiter.sv
// Bench for click_pipe_arbiter with a behavioural 3-deep 2-phase pipeline and a scoreboard.
module tb_click_pipe_arbiter;

  localparam int N = 4, DW = 32, MAXF = 4, SS = 2, IDW = 2, CW = 3, PIPE_DEPTH = 3;

  logic            clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            rsp_ready = 1'b0;
  logic [N-1:0]    req_ready;
  logic            pipe_in_req, pipe_in_ack, pipe_out_req, pipe_out_ack, rsp_valid;
  logic [DW-1:0]   pipe_in_data, pipe_out_data, rsp_data;
  logic [IDW-1:0]  rsp_src;
  logic [CW-1:0]   inflight;

  click_pipe_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_INFLIGHT(MAXF), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_in_req(pipe_in_req), .pipe_in_data(pipe_in_data), .pipe_in_ack(pipe_in_ack),
    .pipe_out_req(pipe_out_req), .pipe_out_data(pipe_out_data), .pipe_out_ack(pipe_out_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_src(rsp_src), .rsp_ready(rsp_ready),
    .inflight(inflight));

  always #5 clk = ~clk;

  // Pipeline model: FIFO of capacity PIPE_DEPTH with random head/tail handshake latency.
  logic [DW-1:0] pq[$];
  logic presented;
  int   hd_dly, tl_dly;
  always @(negedge clk) begin
    if (reset) begin
      pq.delete();
      pipe_in_ack = 1'b0; pipe_out_req = 1'b0; pipe_out_data = '0;
      presented = 1'b0; hd_dly = 0; tl_dly = 0;
    end else begin
      if (presented && pipe_out_ack == pipe_out_req) begin
        void'(pq.pop_front());
        presented = 1'b0;
        tl_dly = $urandom_range(0, 3);
      end
      if (pipe_in_req != pipe_in_ack && pq.size() < PIPE_DEPTH) begin
        if (hd_dly == 0) begin
          pq.push_back(pipe_in_data);
          pipe_in_ack = pipe_in_req;
          hd_dly = $urandom_range(0, 2);
        end else hd_dly--;
      end
      if (!presented && pq.size() > 0) begin
        if (tl_dly == 0) begin
          pipe_out_data = pq[0];
          pipe_out_req  = ~pipe_out_req;
          presented     = 1'b1;
        end else tl_dly--;
      end
    end
  end

  // Reference model state
  int n_checks = 0, n_errors = 0;
  int m_ptr = 0, m_infl = 0, n_acc = 0, n_rsp = 0;
  int g_err = 0, r_err = 0, i_err = 0;
  int acc_log[$];
  logic [IDW+DW-1:0] exp_q[$];
  logic [N-1:0]   s_ready;
  logic           s_fire;
  logic [IDW-1:0] last_src;
  logic [DW-1:0]  last_data;

  // Advance one clock, folding observed accepts/responses into the model.
  task automatic cycle();
    int g;
    @(negedge clk);
    s_ready = req_ready;
    s_fire  = rsp_valid && rsp_ready;
    if (reset) begin
      m_ptr = 0; m_infl = 0; exp_q.delete();
    end else begin
      if (inflight !== CW'(m_infl)) i_err++;
      if (req_ready != '0) begin
        g = -1;
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g < 0 || req_ready !== (N'(1) << g) || m_infl >= MAXF) g_err++;
        else begin
          exp_q.push_back({IDW'(g), req_data[g*DW +: DW]});
          m_ptr = g; m_infl++; n_acc++; acc_log.push_back(g);
        end
      end
      if (s_fire) begin
        if (exp_q.size() == 0 || {rsp_src, rsp_data} !== exp_q[0]) r_err++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_infl--; n_rsp++;
        last_src = rsp_src; last_data = rsp_data;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = ($urandom() << 2) | i;
  endtask

  task automatic test_reset();
    int toggles = 0;
    reset = 1'b1;
    cycle(); cycle();
    n_checks++;
    if ({req_ready, pipe_in_req, pipe_in_data, pipe_out_ack, rsp_valid, rsp_data, rsp_src, inflight} !== '0)
      $display("FAIL reset_outputs: got ready=%b ireq=%b idata=%h oack=%b rv=%b rd=%h src=%0d infl=%0d, need all 0",
               req_ready, pipe_in_req, pipe_in_data, pipe_out_ack, rsp_valid, rsp_data, rsp_src, inflight);
    if ({req_ready, pipe_in_req, pipe_in_data, pipe_out_ack, rsp_valid, rsp_data, rsp_src, inflight} !== '0)
      n_errors++;
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (pipe_in_req !== 1'b0 || pipe_out_ack !== 1'b0 || rsp_valid !== 1'b0 || s_ready !== '0) toggles++;
    end
    n_checks++;
    if (toggles !== 0) begin
      $display("FAIL reset_idle: %0d active cycles, need 0", toggles); n_errors++;
    end
  endtask

  task automatic test_single();
    int ba = n_acc, br = n_rsp;
    rsp_ready = 1'b1;
    randomize_data();
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req_valid = 4'b0100;
    for (int t = 0; t < 20 && n_acc == ba; t++) cycle();
    req_valid = '0;
    n_checks++;
    if (s_ready !== 4'b0100) begin
      $display("FAIL single_grant: req_ready=%b need 0100", s_ready); n_errors++;
    end
    n_checks++;
    if (pipe_in_data !== 32'hDEADBEEF || pipe_in_req !== 1'b0 || inflight !== 3'd1) begin
      $display("FAIL single_setup: data=%h req=%b infl=%0d need deadbeef/0/1", pipe_in_data, pipe_in_req, inflight);
      n_errors++;
    end
    cycle();
    n_checks++;
    if (pipe_in_req !== 1'b1 || pipe_in_data !== 32'hDEADBEEF) begin
      $display("FAIL single_req_edge: req=%b data=%h need 1/deadbeef", pipe_in_req, pipe_in_data); n_errors++;
    end
    for (int t = 0; t < 100 && n_rsp == br; t++) cycle();
    n_checks++;
    if (n_rsp == br || last_src !== 2'd2 || last_data !== 32'hDEADBEEF || inflight !== 3'd0) begin
      $display("FAIL single_rsp: got=%0d src=%0d data=%h infl=%0d need 1/2/deadbeef/0",
               n_rsp - br, last_src, last_data, inflight);
      n_errors++;
    end
  endtask

  task automatic test_round_robin();
    int br = n_rsp, bl = acc_log.size(), prev = m_ptr, bad = 0;
    req_valid = '1;
    for (int t = 0; t < 3000 && n_rsp - br < 16; t++) begin
      randomize_data();
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int t = 0; t < 500 && m_infl != 0; t++) cycle();
    for (int i = bl; i < acc_log.size(); i++) begin
      if (acc_log[i] != (prev + 1) % N) bad++;
      prev = acc_log[i];
    end
    n_checks++;
    if (n_rsp - br < 16 || acc_log.size() - bl < 16) begin
      $display("FAIL rr_count: rsp=%0d acc=%0d need >=16", n_rsp - br, acc_log.size() - bl); n_errors++;
    end
    n_checks++;
    if (bad !== 0) begin
      $display("FAIL rr_order: %0d out-of-order grants, need 0", bad); n_errors++;
    end
    n_checks++;
    if (g_err !== 0 || r_err !== 0 || i_err !== 0) begin
      $display("FAIL rr_scoreboard: grant=%0d rsp=%0d inflight=%0d errors, need 0", g_err, r_err, i_err); n_errors++;
    end
  endtask

  task automatic test_back_pressure();
    int ba = n_acc, br = n_rsp;
    rsp_ready = 1'b0; req_valid = '1;
    for (int t = 0; t < 80; t++) begin randomize_data(); cycle(); end
    n_checks++;
    if (n_acc - ba !== 4 || inflight !== 3'd4 || s_ready !== '0) begin
      $display("FAIL bp_block: accepts=%0d infl=%0d ready=%b need 4/4/0", n_acc - ba, inflight, s_ready); n_errors++;
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int t = 0; t < 300 && n_rsp - br < 4; t++) cycle();
    n_checks++;
    if (n_rsp - br !== 4 || inflight !== 3'd0 || r_err !== 0) begin
      $display("FAIL bp_drain: rsp=%0d infl=%0d rsp_err=%0d need 4/0/0", n_rsp - br, inflight, r_err); n_errors++;
    end
  endtask

  task automatic test_simultaneous();
    int ba = n_acc;
    rsp_ready = 1'b0; randomize_data(); req_valid = 4'b0110;
    for (int t = 0; t < 100 && n_acc - ba < 2; t++) cycle();
    req_valid = '0;
    for (int t = 0; t < 40; t++) cycle();
    n_checks++;
    if (inflight !== 3'd2 || rsp_valid !== 1'b1) begin
      $display("FAIL sim_setup: infl=%0d rsp_valid=%b need 2/1", inflight, rsp_valid); n_errors++;
    end
    randomize_data(); req_valid = 4'b1001; rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    n_checks++;
    if (s_ready == '0 || s_fire !== 1'b1 || inflight !== 3'd2) begin
      $display("FAIL sim_both: ready=%b fire=%b infl=%0d need nonzero/1/2", s_ready, s_fire, inflight); n_errors++;
    end
    for (int t = 0; t < 300 && m_infl != 0; t++) cycle();
    n_checks++;
    if (inflight !== 3'd0 || r_err !== 0 || i_err !== 0) begin
      $display("FAIL sim_order: infl=%0d rsp_err=%0d infl_err=%0d need 0/0/0", inflight, r_err, i_err); n_errors++;
    end
  endtask

  task automatic test_reset_mid();
    int ba = n_acc, br;
    rsp_ready = 1'b0; randomize_data(); req_valid = '1;
    for (int t = 0; t < 100 && n_acc - ba < 2; t++) cycle();
    req_valid = '0;
    cycle();
    n_checks++;
    if (inflight !== 3'd2) begin
      $display("FAIL mid_pre: infl=%0d need 2", inflight); n_errors++;
    end
    reset = 1'b1;
    cycle();
    n_checks++;
    if (pipe_in_req !== 1'b0 || pipe_out_ack !== 1'b0 || inflight !== 3'd0 || rsp_valid !== 1'b0) begin
      $display("FAIL mid_reset: ireq=%b oack=%b infl=%0d rv=%b need 0/0/0/0",
               pipe_in_req, pipe_out_ack, inflight, rsp_valid);
      n_errors++;
    end
    reset = 1'b0;
    cycle();
    ba = n_acc; br = n_rsp;
    rsp_ready = 1'b1; randomize_data(); req_data[DW-1:0] = 32'h0BADF00D; req_valid = 4'b0001;
    for (int t = 0; t < 20 && n_acc == ba; t++) cycle();
    req_valid = '0;
    for (int t = 0; t < 100 && n_rsp == br; t++) cycle();
    n_checks++;
    if (n_rsp == br || last_src !== 2'd0 || last_data !== 32'h0BADF00D || inflight !== 3'd0) begin
      $display("FAIL mid_fresh: got=%0d src=%0d data=%h infl=%0d need 1/0/0badf00d/0",
               n_rsp - br, last_src, last_data, inflight);
      n_errors++;
    end
    n_checks++;
    if (g_err !== 0 || r_err !== 0 || i_err !== 0) begin
      $display("FAIL final_scoreboard: grant=%0d rsp=%0d inflight=%0d errors, need 0", g_err, r_err, i_err);
      n_errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
